// File: rtl/frame_pulse_sequencer.sv
// frame_pulse_sequencer: per-frame pulse windows timed from the V-duty marker; define FPS_SHADOW_EN to latch window config once per frame
module frame_pulse_sequencer #(
  parameter int NCH = 2,
  parameter int CW = 9,
  parameter int SAT = 100
) (
  input  logic              iODCK,
  input  logic              iRst_n,
  input  logic              iV_Duty,
  input  logic [NCH*CW-1:0] iStart,
  input  logic [NCH*CW-1:0] iLen,
  input  logic [NCH-1:0]    iPol,
  output logic [NCH-1:0]    oPulse,
  output logic [CW-1:0]     oCount,
  output logic              oDone,
  output logic              oFrameStart,
  output logic              oOverrun
);
  localparam logic [CW-1:0] SatVal = CW'(SAT);
  logic [CW-1:0] cnt;
  logic vD;
  logic [NCH*CW-1:0] curStart, curLen;
  logic [NCH-1:0] curPol, act;
`ifdef FPS_SHADOW_EN
  // window config is captured during reset and the frame marker so mid-frame edits wait for the next frame
  always_ff @(posedge iODCK)
    if (!iRst_n || iV_Duty) begin
      curStart <= iStart;
      curLen <= iLen;
      curPol <= iPol;
    end
`else
  assign curStart = iStart;
  assign curLen = iLen;
  assign curPol = iPol;
`endif
  // window membership per channel; end bound kept one bit wider so start+len cannot wrap
  always_comb begin
    act = '0;
    for (int k = 0; k < NCH; k++)
      act[k] = ({1'b0, cnt} >= {1'b0, curStart[k*CW +: CW]}) &&
               ({1'b0, cnt} < ({1'b0, curStart[k*CW +: CW]} + {1'b0, curLen[k*CW +: CW]}));
  end
  // frame counter, marker edge detect and registered outputs; reset parks the counter at saturation
  always_ff @(posedge iODCK)
    if (!iRst_n) begin
      cnt <= SatVal;
      vD <= 1'b0;
      oFrameStart <= 1'b0;
      oOverrun <= 1'b0;
      oPulse <= iPol;
    end else begin
      cnt <= iV_Duty ? '0 : (cnt == SatVal ? cnt : cnt + 1'b1);
      vD <= iV_Duty;
      oFrameStart <= iV_Duty & ~vD;
      oOverrun <= iV_Duty & ~vD & (cnt != SatVal);
      oPulse <= act ^ curPol;
    end
  assign oCount = cnt;
  assign oDone = (cnt == SatVal);
endmodule
